// File: rtl/dsp_dot_ctrl.sv
// Dot-product sequencer: streams operand pairs into an external multiply-accumulate DSP and returns the sum.
// Optional macro DSP_DOT_CTRL_SAT_EN: saturate RESULT to the signed RES_W range instead of truncating.
module dsp_dot_ctrl #(
    parameter int unsigned WIDTH_OP1 = 18,
    parameter int unsigned WIDTH_OP2 = 25,
    parameter int unsigned WIDTH_OUT = 48,
    parameter int unsigned DSP_LAT   = 3,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned RES_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [LEN_W-1:0]     LEN,
    input  logic                 ABORT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [RES_W-1:0]     RESULT,
    output logic                 SAT,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic [WIDTH_OP1-1:0] S_OP1,
    input  logic [WIDTH_OP2-1:0] S_OP2,
    output logic                 DSP_EN,
    output logic                 DSP_ACC_EN,
    output logic [WIDTH_OP1-1:0] DSP_OP1,
    output logic [WIDTH_OP2-1:0] DSP_OP2,
    input  logic [WIDTH_OUT-1:0] DSP_OUT
);

    localparam int unsigned DRAIN_W = $clog2(DSP_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FEED   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     beat_cnt_q;
    logic [DRAIN_W-1:0]   drain_cnt_q;

    logic                 busy_q, done_q, s_ready_q, sat_q;
    logic [RES_W-1:0]     result_q;
    logic                 dsp_en_q, dsp_acc_en_q;
    logic [WIDTH_OP1-1:0] dsp_op1_q;
    logic [WIDTH_OP2-1:0] dsp_op2_q;

    logic                 busy_d, done_d, s_ready_d, sat_d;
    logic [RES_W-1:0]     result_d;
    logic                 dsp_en_d, dsp_acc_en_d;
    logic [WIDTH_OP1-1:0] dsp_op1_d;
    logic [WIDTH_OP2-1:0] dsp_op2_d;

    logic                 hs;
    logic                 last_beat;
    logic                 drain_done;
    logic                 first_issued;
    logic [RES_W-1:0]     cap_val;
    logic                 cap_sat;

    assign hs           = S_VALID & s_ready_q;
    assign last_beat    = hs && (beat_cnt_q == (len_q - LEN_W'(1)));
    assign drain_done   = (drain_cnt_q == DRAIN_W'(DSP_LAT));
    assign first_issued = (beat_cnt_q != '0);

    // Conversion of the DSP accumulator to the RESULT width
`ifdef DSP_DOT_CTRL_SAT_EN
    logic fits;
    assign fits    = (&DSP_OUT[WIDTH_OUT-1:RES_W-1]) | ~(|DSP_OUT[WIDTH_OUT-1:RES_W-1]);
    assign cap_sat = ~fits;
    assign cap_val = fits ? DSP_OUT[RES_W-1:0]
                   : (DSP_OUT[WIDTH_OUT-1] ? {1'b1, {(RES_W-1){1'b0}}}
                                           : {1'b0, {(RES_W-1){1'b1}}});
`else
    logic unused_dsp_hi;
    assign unused_dsp_hi = ^DSP_OUT[WIDTH_OUT-1:RES_W];
    assign cap_sat       = 1'b0;
    assign cap_val       = DSP_OUT[RES_W-1:0];
`endif

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ABORT overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = (LEN == '0) ? ST_FINISH : ST_FEED;
                end
            end
            ST_FEED: begin
                if (last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (ABORT) begin
            state_d = ST_IDLE;
        end
    end

    // Next values of the registered outputs, decoded from the upcoming state
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_FINISH);
        s_ready_d    = (state_d == ST_FEED);
        dsp_en_d     = (state_d == ST_FEED) || (state_d == ST_DRAIN);
        dsp_acc_en_d = 1'b0;
        dsp_op1_d    = '0;
        dsp_op2_d    = '0;
        result_d     = result_q;
        sat_d        = sat_q;

        case (state_d)
            ST_FEED, ST_DRAIN: begin
                if (hs) begin
                    dsp_op1_d    = S_OP1;
                    dsp_op2_d    = S_OP2;
                    dsp_acc_en_d = first_issued;
                end else begin
                    dsp_acc_en_d = (state_d == ST_DRAIN) || first_issued;
                end
            end
            default: begin
                dsp_acc_en_d = 1'b0;
            end
        endcase

        if ((state_q == ST_DRAIN) && (state_d == ST_FINISH)) begin
            result_d = cap_val;
            sat_d    = cap_sat;
        end else if ((state_q == ST_IDLE) && (state_d == ST_FINISH)) begin
            result_d = '0;
            sat_d    = 1'b0;
        end
    end

    // Job length, beat and drain counters
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            len_q       <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && START) begin
                len_q <= LEN;
            end
            if (state_d != ST_FEED) begin
                beat_cnt_q <= '0;
            end else if (hs) begin
                beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            end
            if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
                drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end else begin
                drain_cnt_q <= '0;
            end
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            s_ready_q    <= 1'b0;
            sat_q        <= 1'b0;
            result_q     <= '0;
            dsp_en_q     <= 1'b0;
            dsp_acc_en_q <= 1'b0;
            dsp_op1_q    <= '0;
            dsp_op2_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            s_ready_q    <= s_ready_d;
            sat_q        <= sat_d;
            result_q     <= result_d;
            dsp_en_q     <= dsp_en_d;
            dsp_acc_en_q <= dsp_acc_en_d;
            dsp_op1_q    <= dsp_op1_d;
            dsp_op2_q    <= dsp_op2_d;
        end
    end

    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign S_READY    = s_ready_q;
    assign SAT        = sat_q;
    assign RESULT     = result_q;
    assign DSP_EN     = dsp_en_q;
    assign DSP_ACC_EN = dsp_acc_en_q;
    assign DSP_OP1    = dsp_op1_q;
    assign DSP_OP2    = dsp_op2_q;

endmodule

// File: tb/tb_dsp_dot_ctrl.sv
// Bench for dsp_dot_ctrl: behavioural DSP plus sum-of-products reference with saturate/truncate rule.
module tb_dsp_dot_ctrl;

    localparam int unsigned WIDTH_OP1 = 18;
    localparam int unsigned WIDTH_OP2 = 25;
    localparam int unsigned WIDTH_OUT = 48;
    localparam int unsigned DSP_LAT   = 3;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned RES_W     = 32;

    logic                 CLK = 1'b0;
    logic                 RSTN;
    logic                 START;
    logic [LEN_W-1:0]     LEN;
    logic                 ABORT;
    logic                 BUSY;
    logic                 DONE;
    logic [RES_W-1:0]     RESULT;
    logic                 SAT;
    logic                 S_VALID;
    logic                 S_READY;
    logic [WIDTH_OP1-1:0] S_OP1;
    logic [WIDTH_OP2-1:0] S_OP2;
    logic                 DSP_EN;
    logic                 DSP_ACC_EN;
    logic [WIDTH_OP1-1:0] DSP_OP1;
    logic [WIDTH_OP2-1:0] DSP_OP2;
    logic [WIDTH_OUT-1:0] DSP_OUT;

    always #5 CLK = ~CLK;

    dsp_dot_ctrl #(
        .WIDTH_OP1(WIDTH_OP1), .WIDTH_OP2(WIDTH_OP2), .WIDTH_OUT(WIDTH_OUT),
        .DSP_LAT(DSP_LAT), .LEN_W(LEN_W), .RES_W(RES_W)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .LEN(LEN), .ABORT(ABORT),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .SAT(SAT),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_OP1(S_OP1), .S_OP2(S_OP2),
        .DSP_EN(DSP_EN), .DSP_ACC_EN(DSP_ACC_EN), .DSP_OP1(DSP_OP1), .DSP_OP2(DSP_OP2),
        .DSP_OUT(DSP_OUT)
    );

    // Behavioural DSP: product visible on DSP_OUT DSP_LAT cycles after the operands
    longint pp [DSP_LAT-1];
    logic   pa [DSP_LAT-1];
    logic   pe [DSP_LAT-1];
    longint dsp_acc;
    assign DSP_OUT = WIDTH_OUT'(dsp_acc);

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < int'(DSP_LAT) - 1; i++) begin
                pp[i] <= 0;
                pa[i] <= 1'b0;
                pe[i] <= 1'b0;
            end
            dsp_acc <= 0;
        end else begin
            pp[0] <= longint'($signed(DSP_OP1)) * longint'($signed(DSP_OP2));
            pa[0] <= DSP_ACC_EN;
            pe[0] <= DSP_EN;
            for (int i = 1; i < int'(DSP_LAT) - 1; i++) begin
                pp[i] <= pp[i-1];
                pa[i] <= pa[i-1];
                pe[i] <= pe[i-1];
            end
            if (pe[DSP_LAT-2]) begin
                dsp_acc <= pa[DSP_LAT-2] ? dsp_acc + pp[DSP_LAT-2] : pp[DSP_LAT-2];
            end
        end
    end

    int     checks   = 0;
    int     failures = 0;
    int     op1_q[$];
    int     op2_q[$];
    int     gap_lo, gap_hi;
    bit     poke_start;
    longint last_exp;
    bit     last_sat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint ref_result(input longint sum);
        logic [63:0] s;
        longint mx, mn;
        s  = sum;
        mx = (longint'(1) <<< (RES_W - 1)) - 1;
        mn = -(longint'(1) <<< (RES_W - 1));
`ifdef DSP_DOT_CTRL_SAT_EN
        if (sum > mx) return mx;
        if (sum < mn) return mn;
        return sum;
`else
        if (mx < mn) return 0;
        return longint'($signed(s[RES_W-1:0]));
`endif
    endfunction

    function automatic bit ref_sat(input longint sum);
`ifdef DSP_DOT_CTRL_SAT_EN
        return (sum != ref_result(sum));
`else
        if (sum == 0) return 1'b0;
        return 1'b0;
`endif
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   64'(BUSY),       0);
        chk({tag, "_done"},   64'(DONE),       0);
        chk({tag, "_ready"},  64'(S_READY),    0);
        chk({tag, "_result"}, 64'(RESULT),     0);
        chk({tag, "_sat"},    64'(SAT),        0);
        chk({tag, "_dsp_en"}, 64'(DSP_EN),     0);
        chk({tag, "_acc_en"}, 64'(DSP_ACC_EN), 0);
        chk({tag, "_op1"},    64'(DSP_OP1),    0);
        chk({tag, "_op2"},    64'(DSP_OP2),    0);
    endtask

    // Runs one job from op1_q/op2_q; called and returns on a falling edge
    task automatic run_job(input string tag, input int len);
        longint sum = 0;
        longint exp_res;
        bit     exp_sat;
        int     idx = 0, cyc = 0, last_hs = -1, done_cyc = -1, dones = 0, gap = 0;
        int     budget;
        bit     drove = 0, bubble = 0, poked = 0, saw_ready = 0, saw_en = 0;
        for (int i = 0; i < len; i++) sum += longint'(op1_q[i]) * longint'(op2_q[i]);
        exp_res = ref_result(sum);
        exp_sat = ref_sat(sum);
        budget  = len * (gap_hi + 1) + 40;
        START = 1'b1;
        LEN   = LEN_W'(len);
        @(negedge CLK);
        START = 1'b0;
        while (cyc < budget && !(done_cyc >= 0 && cyc > done_cyc + 1)) begin
            if (drove) begin
                chk({tag, "_beat_op1"}, $signed(DSP_OP1), longint'(op1_q[idx]));
                chk({tag, "_beat_op2"}, $signed(DSP_OP2), longint'(op2_q[idx]));
                chk({tag, "_beat_acc_en"}, 64'(DSP_ACC_EN), 64'(idx != 0));
                idx++;
            end else if (bubble) begin
                chk({tag, "_bub_ops"}, 64'(DSP_OP1 | WIDTH_OP1'(DSP_OP2)), 0);
                chk({tag, "_bub_acc_en"}, 64'(DSP_ACC_EN), 64'(idx != 0));
            end
            saw_ready |= S_READY;
            saw_en    |= DSP_EN;
            if (DONE) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk({tag, "_done_time"}, 64'(cyc),
                        (len == 0) ? 64'(0) : 64'(last_hs + int'(DSP_LAT) + 2));
                    chk({tag, "_result"}, $signed(RESULT), exp_res);
                    chk({tag, "_sat"}, 64'(SAT), 64'(exp_sat));
                    chk({tag, "_busy_at_done"}, 64'(BUSY), 1);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) chk({tag, "_busy_after"}, 64'(BUSY), 0);
            S_VALID = 1'b0;
            START   = 1'b0;
            drove   = 0;
            bubble  = 0;
            if (poke_start && idx == 1 && !poked) begin
                START = 1'b1;
                LEN   = '0;
                poked = 1;
            end
            if (S_READY) begin
                if (gap == 0 && idx < len) begin
                    S_VALID = 1'b1;
                    S_OP1   = WIDTH_OP1'(op1_q[idx]);
                    S_OP2   = WIDTH_OP2'(op2_q[idx]);
                    drove   = 1;
                    last_hs = cyc;
                    gap     = $urandom_range(gap_hi, gap_lo);
                end else begin
                    bubble = 1;
                    if (gap > 0) gap--;
                end
            end
            @(negedge CLK);
            cyc++;
        end
        S_VALID = 1'b0;
        START   = 1'b0;
        chk({tag, "_done_count"}, 64'(dones), 1);
        chk({tag, "_beats"}, 64'(idx), 64'(len));
        if (len == 0) begin
            chk({tag, "_ready_seen"}, 64'(saw_ready), 0);
            chk({tag, "_dsp_en_seen"}, 64'(saw_en), 0);
        end
        last_exp = exp_res;
        last_sat = exp_sat;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        RSTN = 1'b0; START = 1'b0; LEN = '0; ABORT = 1'b0;
        S_VALID = 1'b0; S_OP1 = '0; S_OP2 = '0;
        gap_lo = 0; gap_hi = 0; poke_start = 0; last_exp = 0; last_sat = 0;
        repeat (2) @(negedge CLK);
        chk_reset("por");
        RSTN = 1'b1;
        @(negedge CLK);

        op1_q = '{1, 3, -5, 7}; op2_q = '{2, 4, 6, -8};
        run_job("back2back", 4);
        chk("back2back_value", last_exp, -72);

        gap_lo = 2; gap_hi = 2;
        op1_q = '{2, 4, 6}; op2_q = '{3, 5, 7};
        run_job("gapped", 3);
        chk("gapped_value", last_exp, 68);
        gap_lo = 0; gap_hi = 0;

        run_job("len0", 0);

        // Abort after two accepted beats
        op1_q = '{1, 2, 3, 4, 5}; op2_q = '{1, 1, 1, 1, 1};
        START = 1'b1; LEN = LEN_W'(5);
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            S_VALID = 1'b1; S_OP1 = WIDTH_OP1'(op1_q[i]); S_OP2 = WIDTH_OP2'(op2_q[i]);
            @(negedge CLK);
        end
        S_VALID = 1'b0; ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_busy", 64'(BUSY), 0);
        chk("abort_ready", 64'(S_READY), 0);
        chk("abort_result", $signed(RESULT), last_exp);
        chk("abort_sat", 64'(SAT), 64'(last_sat));
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            dones += int'(DONE);
            @(negedge CLK);
        end
        chk("abort_no_done", 64'(dones), 0);
        op1_q = '{3}; op2_q = '{3};
        run_job("after_abort", 1);
        chk("after_abort_value", last_exp, 9);

        // Reset asserted mid-FEED
        op1_q = '{7, 7, 7}; op2_q = '{7, 7, 7};
        START = 1'b1; LEN = LEN_W'(3);
        @(negedge CLK);
        START = 1'b0; S_VALID = 1'b1; S_OP1 = WIDTH_OP1'(7); S_OP2 = WIDTH_OP2'(7);
        @(negedge CLK);
        S_VALID = 1'b0;
        RSTN = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        op1_q = '{-4}; op2_q = '{5};
        run_job("after_reset", 1);
        chk("after_reset_value", last_exp, -20);

        op1_q = '{131071, 131071}; op2_q = '{16777215, 16777215};
        run_job("sat", 2);

        // Random jobs: full-range and small operands, random gaps, START pokes while busy
        poke_start = 1;
        for (int j = 0; j < 6; j++) begin
            int len;
            len = $urandom_range(10, 1);
            gap_lo = 0; gap_hi = (j % 2 == 0) ? 0 : 3;
            op1_q.delete(); op2_q.delete();
            for (int i = 0; i < len; i++) begin
                if (j < 3) begin
                    op1_q.push_back(int'($urandom_range(262143, 0)) - 131072);
                    op2_q.push_back(int'($urandom_range(33554431, 0)) - 16777216);
                end else begin
                    op1_q.push_back(int'($urandom_range(2000, 0)) - 1000);
                    op2_q.push_back(int'($urandom_range(2000, 0)) - 1000);
                end
            end
            run_job("random", len);
        end
        poke_start = 0;
        gap_lo = 0; gap_hi = 0;

        // Maximum length job
        op1_q.delete(); op2_q.delete();
        for (int i = 0; i < 65535; i++) begin
            op1_q.push_back(int'($urandom_range(6, 0)) - 3);
            op2_q.push_back(int'($urandom_range(6, 0)) - 3);
        end
        run_job("maxlen", 65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_dot_ctrl.md
DSP_DOT_CTRL -- requirements
Module: dsp_dot_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH_OP1, 18, DSP operand-1 width; WIDTH_OP2, 25, DSP operand-2 width; WIDTH_OUT, 48, DSP accumulator width; DSP_LAT, 3, cycles from DSP_OP* presented to product visible in DSP_OUT; LEN_W, 16, length field width; RES_W, 32, RESULT width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- RSTN, in, 1, asynchronous active-low reset.
- START, in, 1, one-cycle job request, honoured only in IDLE.
- LEN, in, LEN_W, number of operand pairs, sampled with START.
- ABORT, in, 1, cancel job, return to IDLE.
- BUSY, out, 1, high in any state except IDLE.
- DONE, out, 1, one-cycle completion pulse.
- RESULT, out, RES_W, signed dot product, held until next DONE.
- SAT, out, 1, result saturated, valid with DONE.
- S_VALID, in, 1, operand pair valid.
- S_READY, out, 1, controller accepts operand pair.
- S_OP1, in, WIDTH_OP1, signed operand 1.
- S_OP2, in, WIDTH_OP2, signed operand 2.
- DSP_EN, out, 1, DSP enable.
- DSP_ACC_EN, out, 1, 0 = load product, 1 = add product to accumulator.
- DSP_OP1, out, WIDTH_OP1, DSP operand 1.
- DSP_OP2, out, WIDTH_OP2, DSP operand 2.
- DSP_OUT, in, WIDTH_OUT, DSP accumulator output.

Function
REQ-003 FSM states SHALL be IDLE, FEED, DRAIN, FINISH.
REQ-004 IDLE -> FEED on START with LEN>0; START with LEN=0 SHALL go to FINISH directly with RESULT=0, SAT=0, no beat issued.
REQ-005 START while BUSY SHALL be ignored.
REQ-006 In FEED, S_READY SHALL be 1 while beats issued < LEN; handshake = S_VALID & S_READY; S_READY SHALL be 0 in every other state.
REQ-007 DSP_* outputs SHALL be registered: a beat accepted at edge N SHALL appear on DSP_OP1/OP2 in cycle N+1.
REQ-008 First beat of a job SHALL be issued with DSP_ACC_EN=0; later beats with DSP_ACC_EN=1.
REQ-009 Bubble (FEED, no handshake) SHALL drive DSP_OP1=DSP_OP2=0, DSP_ACC_EN=0 before first beat, 1 after.
REQ-010 DSP_EN SHALL be 1 in FEED and DRAIN, 0 in IDLE and FINISH.
REQ-011 After the LEN-th beat, FEED -> DRAIN; DRAIN SHALL drive zeros with DSP_ACC_EN=1 for DSP_LAT cycles, then capture DSP_OUT into RESULT and go to FINISH.
REQ-012 Capture SHALL occur exactly DSP_LAT cycles after the last beat is presented on DSP_OP*.
REQ-013 FINISH SHALL assert DONE for one cycle, then return to IDLE; BUSY SHALL fall in the cycle after DONE.
REQ-014 ABORT SHALL take priority over all transitions: next state IDLE, no DONE, RESULT and SAT unchanged, beat counter cleared.
REQ-015 Beat and drain counters SHALL not wrap; LEN = 2^LEN_W-1 SHALL complete correctly.

Reset
REQ-016 RSTN low SHALL asynchronously force IDLE, counters 0, BUSY=0, DONE=0, S_READY=0, RESULT=0, SAT=0, DSP_EN=0, DSP_ACC_EN=0, DSP_OP1=DSP_OP2=0.
REQ-017 Reset mid-job SHALL discard the job; the first START after reset release SHALL run normally.

Configuration
REQ-018 Macro DSP_DOT_CTRL_SAT_EN defined: RESULT SHALL be DSP_OUT saturated to the signed RES_W range; SAT=1 when clipping occurred.
REQ-019 Macro undefined: RESULT SHALL be DSP_OUT[RES_W-1:0] (truncation); SAT SHALL be tied 0.

Verification
REQ-020 LEN=4, pairs (1,2),(3,4),(-5,6),(7,-8), S_VALID always 1 -> DONE once, RESULT=-72, SAT=0, DONE 4+DSP_LAT+1 cycles after first handshake.
REQ-021 LEN=3, pairs (2,3),(4,5),(6,7), 2-cycle S_VALID gap between beats -> RESULT=68; bubbles show DSP_OP*=0, DSP_ACC_EN=1.
REQ-022 LEN=0 START -> DONE next cycle, RESULT=0, S_READY never 1, DSP_EN never 1.
REQ-023 LEN=5, ABORT after 2 beats -> IDLE, no DONE; following job LEN=1 (3,3) -> RESULT=9, proving accumulator reload.
REQ-024 SAT_EN defined, RES_W=32, LEN=2, pairs (131071,16777215) twice -> RESULT=2147483647, SAT=1; macro undefined -> RESULT = low 32 bits of sum, SAT=0.
REQ-025 RSTN asserted mid-FEED -> all outputs at reset values same cycle; START after release LEN=1 (-4,5) -> RESULT=-20.
